snk68_clk_en: RTL and testbench

Clock-enable generator sitting directly downstream of the 72 MHz system PLL. It turns the single 72 MHz `clk_sys` plus the PLL `locked` flag into a filtered core reset and the single-cycle enable strobes the SNK68 core needs:
- 68000 phi1/phi2 at 9 MHz;
- pixel at 6 MHz;
- Z80/YM3812 at 4 MHz;
- uPD7759 at 640 kHz.

All downstream logic runs on `clk_sys` and is qualified by these strobes.

---
 rtl/snk68_clk_pkg.sv | 28 ++
 rtl/ce_frac.sv | 37 +++
 rtl/snk68_clk_en.sv | 112 +++++++++++
 tb/tb_snk68_clk_en.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snk68_clk_pkg.sv
// Shared constants for the SNK68 clock-enable generator: channel ratios,
// nominal system clock and CPU phase slots.
package snk68_clk_pkg;

   localparam int unsigned CLK_SYS_HZ = 72_000_000;

   localparam int PIX_NUM   = 1;
   localparam int PIX_DEN   = 12;
   localparam int SND_NUM   = 1;
   localparam int SND_DEN   = 18;
   localparam int ADPCM_NUM = 2;
   localparam int ADPCM_DEN = 225;

   localparam logic [2:0] PHI1_SLOT = 3'd0;
   localparam logic [2:0] PHI2_SLOT = 3'd4;

   typedef enum logic [1:0] {
      ST_LOCK   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FROZEN = 2'd2
   } clk_state_e;

   // Average strobe rate of a NUM/DEN channel off the nominal system clock.
   function automatic int unsigned ce_hz(input int unsigned num, input int unsigned den);
      return (CLK_SYS_HZ / den) * num;
   endfunction

endpackage

// File: rtl/ce_frac.sv
// Fractional clock enable: strobes NUM times every DEN unheld cycles.
// The registered strobe is computed one cycle ahead, so clr/hold describe the next cycle.
module ce_frac #(
   parameter int NUM   = 1,
   parameter int DEN   = 12,
   parameter int ACC_W = 8
) (
   input  logic clk,
   input  logic clr,
   input  logic hold,
   output logic ce
);

   localparam logic [ACC_W:0] NUM_V = (ACC_W+1)'(NUM);
   localparam logic [ACC_W:0] DEN_V = (ACC_W+1)'(DEN);

   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;

   assign sum = {1'b0, acc} + NUM_V;

   always_ff @(posedge clk) begin
      if (clr) begin
         acc <= '0;
         ce  <= 1'b0;
      end else if (hold) begin
         ce  <= 1'b0;
      end else if (sum >= DEN_V) begin
         acc <= ACC_W'(sum - DEN_V);
         ce  <= 1'b1;
      end else begin
         acc <= sum[ACC_W-1:0];
         ce  <= 1'b0;
      end
   end

endmodule

// File: rtl/snk68_clk_en.sv
// SNK68 clock-enable generator: PLL lock filter, 68000 phase strobes and
// fractional pixel/sound/ADPCM strobes with a pause freeze.
//
// state     | meaning
// ST_LOCK   | core held in reset, waiting for LOCK_DLY consecutive locked cycles
// ST_RUN    | strobes running
// ST_FROZEN | paused: CPU parked at slot 5, snd/adpcm held, pix still running
module snk68_clk_en
   import snk68_clk_pkg::*;
#(
   parameter int LOCK_DLY = 1024,
   parameter int ACC_W    = 8
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic pll_locked,
   input  logic pause,
   output logic core_reset,
   output logic cpu_phi1_ce,
   output logic cpu_phi2_ce,
   output logic pix_ce,
   output logic snd_ce,
   output logic adpcm_ce,
   output logic pause_ack
);

   localparam int LOCK_W = $clog2(LOCK_DLY + 1);

   if ((1 << ACC_W) < ADPCM_DEN || ce_hz(ADPCM_NUM, ADPCM_DEN) != 640_000) begin : g_bad_cfg
      $error("snk68_clk_en: accumulator too narrow or ADPCM ratio off");
   end

   clk_state_e        state, state_next;
   logic [LOCK_W-1:0] lock_cnt;
   logic [2:0]        cpu_cnt, cpu_cnt_next;
   logic              frac_clr, frac_hold;

   always_comb begin
      state_next = state;
      if (reset || !pll_locked) begin
         state_next = ST_LOCK;
      end else begin
         case (state)
            ST_LOCK:   if (lock_cnt == '0) state_next = ST_RUN;
            ST_RUN:    if (pause && cpu_cnt == PHI2_SLOT) state_next = ST_FROZEN;
            ST_FROZEN: if (!pause) state_next = ST_RUN;
            default:   state_next = ST_LOCK;
         endcase
      end
   end

   // The first run cycle always starts at phi1; a frozen cycle does not advance.
   always_comb begin
      cpu_cnt_next = cpu_cnt + 3'd1;
      if (state_next == ST_LOCK || state == ST_LOCK) begin
         cpu_cnt_next = '0;
      end else if (state == ST_FROZEN) begin
         cpu_cnt_next = cpu_cnt;
      end
   end

   assign frac_clr  = (state_next == ST_LOCK);
   assign frac_hold = (state_next == ST_FROZEN);

   always_ff @(posedge clk_sys) begin
      if (reset || !pll_locked) begin
         lock_cnt <= LOCK_W'(LOCK_DLY - 1);
      end else if (state == ST_LOCK && lock_cnt != '0) begin
         lock_cnt <= lock_cnt - LOCK_W'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state       <= ST_LOCK;
         cpu_cnt     <= '0;
         core_reset  <= 1'b1;
         cpu_phi1_ce <= 1'b0;
         cpu_phi2_ce <= 1'b0;
         pause_ack   <= 1'b0;
      end else begin
         state       <= state_next;
         cpu_cnt     <= cpu_cnt_next;
         core_reset  <= (state_next == ST_LOCK);
         cpu_phi1_ce <= (state_next != ST_LOCK) && (cpu_cnt_next == PHI1_SLOT);
         cpu_phi2_ce <= (state_next != ST_LOCK) && (cpu_cnt_next == PHI2_SLOT);
         pause_ack   <= (state_next == ST_FROZEN);
      end
   end

   ce_frac #(.NUM(PIX_NUM), .DEN(PIX_DEN), .ACC_W(ACC_W)) u_pix (
      .clk  (clk_sys),
      .clr  (frac_clr),
      .hold (1'b0),
      .ce   (pix_ce)
   );

   ce_frac #(.NUM(SND_NUM), .DEN(SND_DEN), .ACC_W(ACC_W)) u_snd (
      .clk  (clk_sys),
      .clr  (frac_clr),
      .hold (frac_hold),
      .ce   (snd_ce)
   );

   ce_frac #(.NUM(ADPCM_NUM), .DEN(ADPCM_DEN), .ACC_W(ACC_W)) u_adpcm (
      .clk  (clk_sys),
      .clr  (frac_clr),
      .hold (frac_hold),
      .ce   (adpcm_ce)
   );

endmodule

// File: tb/tb_snk68_clk_en.sv
// Bench for snk68_clk_en: per-cycle reference model plus directed timing scenarios
// and a randomized pause/lock/reset run.
module tb_snk68_clk_en;

   localparam int LOCK_DLY = 16;

   logic clk_sys    = 1'b0;
   logic reset      = 1'b1;
   logic pll_locked = 1'b0;
   logic pause      = 1'b0;
   logic core_reset, cpu_phi1_ce, cpu_phi2_ce, pix_ce, snd_ce, adpcm_ce, pause_ack;

   int errors = 0;
   int checks = 0;

   // Model: consecutive-lock count, run state, and per-channel step counts since N.
   int lock_run = 0;
   bit m_rst = 1'b1;
   bit m_frz = 1'b0;
   int cpu_k = 0, pix_k = 0, snd_k = 0, ad_k = 0;
   logic [6:0] exp_v, act_v;

   always #7 clk_sys = ~clk_sys;

   snk68_clk_en #(.LOCK_DLY(LOCK_DLY), .ACC_W(8)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .pll_locked  (pll_locked),
      .pause       (pause),
      .core_reset  (core_reset),
      .cpu_phi1_ce (cpu_phi1_ce),
      .cpu_phi2_ce (cpu_phi2_ce),
      .pix_ce      (pix_ce),
      .snd_ce      (snd_ce),
      .adpcm_ce    (adpcm_ce),
      .pause_ack   (pause_ack)
   );

   // A NUM/DEN channel on step k strobes when floor(k*NUM/DEN) steps up.
   function automatic bit frac_ce(input int k, input int num, input int den);
      return ((k + 1) * num) / den != (k * num) / den;
   endfunction

   task automatic cyc();
      bit nf;
      @(posedge clk_sys);
      if (reset || !pll_locked) begin
         lock_run = 0;
         m_rst    = 1'b1;
         m_frz    = 1'b0;
      end else if (m_rst) begin
         lock_run++;
         if (lock_run >= LOCK_DLY) begin
            m_rst = 1'b0;
            m_frz = 1'b0;
            cpu_k = 0; pix_k = 0; snd_k = 0; ad_k = 0;
         end
      end else begin
         nf = m_frz ? pause : (pause && (cpu_k % 8) == 4);
         pix_k++;
         if (!m_frz) begin
            cpu_k++; snd_k++; ad_k++;
         end
         m_frz = nf;
      end
      @(negedge clk_sys);
      act_v = {core_reset, cpu_phi1_ce, cpu_phi2_ce, pix_ce, snd_ce, adpcm_ce, pause_ack};
      if (m_rst) exp_v = 7'b1000000;
      else exp_v = {1'b0,
                    !m_frz && (cpu_k % 8) == 0,
                    !m_frz && (cpu_k % 8) == 4,
                    frac_ce(pix_k, 1, 12),
                    !m_frz && frac_ce(snd_k, 1, 18),
                    !m_frz && frac_ce(ad_k, 2, 225),
                    m_frz};
   endtask

   task automatic test_reset();
      reset = 1'b1; pll_locked = 1'b1; pause = 1'b0;
      repeat (3) begin
         cyc();
         checks++;
         if (act_v !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", act_v, 7'b1000000);
         end
      end
   endtask

   task automatic test_lock();
      int n = -1;
      reset = 1'b0; pll_locked = 1'b1;
      for (int i = 1; i <= 40 && n < 0; i++) begin
         cyc();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL lock_seq cyc=%0d got=%b want=%b", i, act_v, exp_v);
         end
         if (core_reset === 1'b0) n = i;
      end
      checks++;
      if (n != LOCK_DLY) begin
         errors++;
         $display("FAIL lock_dly got=%0d want=%0d", n, LOCK_DLY);
      end
      checks++;
      if (cpu_phi1_ce !== 1'b1) begin
         errors++;
         $display("FAIL phi1_at_N got=%b want=1", cpu_phi1_ce);
      end
   endtask

   task automatic test_free_run();
      int c1, c2, cp, cs, ca, both;
      c1 = int'(cpu_phi1_ce); c2 = int'(cpu_phi2_ce); cp = int'(pix_ce);
      cs = int'(snd_ce); ca = int'(adpcm_ce); both = 0;
      for (int i = 1; i < 9000; i++) begin
         cyc();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL free_run t=%0d got=%b want=%b", i, act_v, exp_v);
         end
         c1 += int'(cpu_phi1_ce); c2 += int'(cpu_phi2_ce); cp += int'(pix_ce);
         cs += int'(snd_ce); ca += int'(adpcm_ce);
         if (cpu_phi1_ce && cpu_phi2_ce) both++;
      end
      checks++;
      if (c1 != 1125 || c2 != 1125) begin
         errors++;
         $display("FAIL phi_counts got=%0d/%0d want=1125/1125", c1, c2);
      end
      checks++;
      if (cp != 750 || cs != 500 || ca != 80) begin
         errors++;
         $display("FAIL frac_counts got=%0d/%0d/%0d want=750/500/80", cp, cs, ca);
      end
      checks++;
      if (both != 0) begin
         errors++;
         $display("FAIL phi_overlap got=%0d want=0", both);
      end
   endtask

   task automatic test_lock_drop();
      repeat (37) cyc();
      pll_locked = 1'b0;
      cyc();
      checks++;
      if (act_v !== 7'b1000000) begin
         errors++;
         $display("FAIL lock_drop got=%b want=%b", act_v, 7'b1000000);
      end
      test_lock();
   endtask

   task automatic test_pause();
      int t = 0;
      int bad = 0;
      int snd_at = -1, ad_at = -1;
      cyc(); t++;
      pause = 1'b1;
      repeat (3) begin cyc(); t++; end
      checks++;
      if (cpu_phi2_ce !== 1'b1 || pause_ack !== 1'b0) begin
         errors++;
         $display("FAIL pause_phi2 t=%0d got=%b%b want=10", t, cpu_phi2_ce, pause_ack);
      end
      for (int i = 0; i < 30; i++) begin
         cyc(); t++;
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL pause_model t=%0d got=%b want=%b", t, act_v, exp_v);
         end
         if (pause_ack !== 1'b1 || cpu_phi1_ce || cpu_phi2_ce || snd_ce || adpcm_ce) bad++;
         if (pix_ce !== ((t % 12) == 11)) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL paused_outputs bad_cycles=%0d want=0", bad);
      end
      pause = 1'b0;
      cyc(); t++;
      checks++;
      if (pause_ack !== 1'b0) begin
         errors++;
         $display("FAIL release_ack got=%b want=0", pause_ack);
      end
      // t is now R; five active cycles (N..N+4) preceded the freeze
      for (int r = 1; r <= 110; r++) begin
         cyc(); t++;
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL resume_model r=%0d got=%b want=%b", r, act_v, exp_v);
         end
         if (r == 3 && cpu_phi1_ce !== 1'b1) begin
            errors++;
            $display("FAIL resume_phi1 r=3 got=%b want=1", cpu_phi1_ce);
         end
         if (r == 7 && cpu_phi2_ce !== 1'b1) begin
            errors++;
            $display("FAIL resume_phi2 r=7 got=%b want=1", cpu_phi2_ce);
         end
         if (snd_ce && snd_at < 0) snd_at = r;
         if (adpcm_ce && ad_at < 0) ad_at = r;
      end
      checks++;
      if (snd_at != 17 - 5 || ad_at != 112 - 5) begin
         errors++;
         $display("FAIL resume_spacing got snd=%0d adpcm=%0d want snd=%0d adpcm=%0d",
                  snd_at, ad_at, 17 - 5, 112 - 5);
      end
   endtask

   task automatic test_reset_mid_pause();
      int k = 0;
      int pix_at = -1, snd_at = -1;
      pause = 1'b1;
      while (pause_ack !== 1'b1 && k < 12) begin cyc(); k++; end
      checks++;
      if (pause_ack !== 1'b1) begin
         errors++;
         $display("FAIL freeze_timeout got=%b want=1", pause_ack);
      end
      reset = 1'b1;
      cyc();
      checks++;
      if (act_v !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_mid_pause got=%b want=%b", act_v, 7'b1000000);
      end
      pause = 1'b0;
      test_lock();
      for (int t = 1; t <= 18; t++) begin
         cyc();
         if (pix_ce && pix_at < 0) pix_at = t;
         if (snd_ce && snd_at < 0) snd_at = t;
      end
      checks++;
      if (pix_at != 11 || snd_at != 17) begin
         errors++;
         $display("FAIL cleared_counters got pix=%0d snd=%0d want pix=11 snd=17", pix_at, snd_at);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         reset      = ($urandom_range(0, 999) < 2);
         pll_locked = ($urandom_range(0, 599) != 0);
         if ($urandom_range(0, 19) == 0) pause = ~pause;
         cyc();
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL random i=%0d got=%b want=%b", i, act_v, exp_v);
         end
      end
      reset = 1'b0; pll_locked = 1'b1; pause = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lock();
      test_free_run();
      test_lock_drop();
      test_pause();
      test_reset_mid_pause();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
